// File: rtl/ram_dump_pkg.sv
// Shared types and defaults for the post-halt data RAM dump unit.
// Defines the FSM encoding and the default geometry of the dumped RAM.
package ram_dump_pkg;

  localparam int DEPTH_DEF     = 512;
  localparam int ADDR_W_DEF    = 9;
  localparam int DATA_W_DEF    = 32;
  localparam int TRAILER_INDEX = DEPTH_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dump_state_t;

endpackage

// File: rtl/dump_fifo2.sv
// Two-entry FIFO holding {index, data} beats between the RAM read port and the output.
// Latency: a pushed entry is visible at the head one edge later; pop and push may share an edge.
// Backpressure: none internally; the caller bounds pushes so it never overflows.
module dump_fifo2 #(
  parameter int W = 41
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [1:0]   count,
  output logic         empty,
  output logic         full
);

  logic [W-1:0] mem_q [2];
  logic         wp_q;
  logic         rp_q;
  logic [1:0]   cnt_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) wp_q <= ~wp_q;
      if (pop)  rp_q <= ~rp_q;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

  assign rdata = mem_q[rp_q];
  assign count = cnt_q;
  assign empty = (cnt_q == 2'd0);
  assign full  = (cnt_q == 2'd2);

endmodule

// File: rtl/ram_dump_unit.sv
// Walks the data RAM 0..DEPTH-1 after CPU halt and streams words out (RAM_DUMP_CHECKSUM_EN adds a sum trailer).
// Latency: first beat valid 2 cycles after the trigger edge; one beat per cycle with the sink ready.
// Backpressure: reads are throttled so buffered plus in-flight words never exceed two; output holds while stalled.
module ram_dump_unit
  import ram_dump_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stop_i,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout_data,
  output logic [ADDR_W:0]   dout_index,
  output logic              busy,
  output logic              done
);

  localparam int                FW        = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  dump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W-1:0] infl_idx_q;
  logic              infl_q;
  logic              fire, pop, push, drain_exit;
  logic [1:0]        fcount;
  logic              fempty, ffull;
  logic [FW-1:0]     fhead;
  logic [2:0]        occ;

  assign fire = dout_valid & dout_ready;
  assign pop  = fire & ~fempty;
  assign push = infl_q & (~ffull | pop);

  // A beat leaving on this edge frees its slot, which keeps the stream at full rate.
  assign occ       = {1'b0, fcount} + {2'b00, infl_q} - {2'b00, pop};
  assign ram_rd_en = (state_q == READ) && (occ < 3'd2);
  assign ram_addr  = rd_ptr_q;
  assign busy      = (state_q == READ) || (state_q == DRAIN);
  assign done      = (state_q == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      infl_q     <= 1'b0;
      infl_idx_q <= '0;
    end else begin
      state_q <= state_d;
      infl_q  <= ram_rd_en;
      if (ram_rd_en) begin
        infl_idx_q <= rd_ptr_q;
        if (rd_ptr_q != LAST_ADDR) rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (stop_i) state_d = READ;
      READ:    if (ram_rd_en && (rd_ptr_q == LAST_ADDR)) state_d = DRAIN;
      DRAIN:   if (drain_exit) state_d = DONE;
      default: state_d = DONE;
    endcase
  end

  dump_fifo2 #(.W(FW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({infl_idx_q, ram_rdata}),
    .rdata (fhead),
    .count (fcount),
    .empty (fempty),
    .full  (ffull)
  );

`ifdef RAM_DUMP_CHECKSUM_EN
  localparam logic [ADDR_W:0] TRL_IDX = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] sum_q;
  logic              trl_vld;

  // Every issued read has been drained once the FIFO is empty with nothing in flight.
  assign trl_vld = (state_q == DRAIN) && fempty && !infl_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     sum_q <= '0;
    else if (pop) sum_q <= sum_q + fhead[DATA_W-1:0];
  end

  assign dout_valid = ~fempty | trl_vld;
  assign dout_data  = !fempty ? fhead[DATA_W-1:0] : (trl_vld ? sum_q : '0);
  assign dout_index = !fempty ? {1'b0, fhead[FW-1:DATA_W]} : (trl_vld ? TRL_IDX : '0);
  assign drain_exit = fire & trl_vld;
`else
  assign dout_valid = ~fempty;
  assign dout_data  = fempty ? '0 : fhead[DATA_W-1:0];
  assign dout_index = fempty ? '0 : {1'b0, fhead[FW-1:DATA_W]};
  assign drain_exit = pop && (fcount == 2'd1) && !infl_q;
`endif

endmodule

// File: tb/tb_ram_dump_unit.sv
// Scoreboard bench for ram_dump_unit: expected beats are queued at read issue and compared at handshake.
module tb_ram_dump_unit;

  localparam int DEPTH = 512;
`ifdef RAM_DUMP_CHECKSUM_EN
  localparam int TRL = 1;
`else
  localparam int TRL = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stop_i;
  logic        ram_rd_en;
  logic [8:0]  ram_addr;
  logic [31:0] ram_rdata;
  logic        dout_valid;
  logic        dout_ready;
  logic [31:0] dout_data;
  logic [9:0]  dout_index;
  logic        busy;
  logic        done;

  ram_dump_unit dut (
    .clk        (clk),
    .rst        (rst),
    .stop_i     (stop_i),
    .ram_rd_en  (ram_rd_en),
    .ram_addr   (ram_addr),
    .ram_rdata  (ram_rdata),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_data  (dout_data),
    .dout_index (dout_index),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({ram_rd_en, ram_addr, dout_valid, dout_data, dout_index, busy, done});
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: synchronous read, data valid the cycle after the strobe.
  logic [31:0] mem [DEPTH];
  logic [31:0] exp_sum;
  logic        pend = 1'b0;
  logic [8:0]  pa = '0;

  always @(negedge clk) begin
    pend = ram_rd_en;
    pa   = ram_addr;
  end

  always @(posedge clk) begin
    #1;
    if (pend) ram_rdata = mem[pa];
  end

  // Sink ready: forced level or ~30% random duty, changed just after each edge.
  logic rand_rdy = 1'b0;
  logic force_rdy = 1'b0;

  always @(posedge clk) begin
    #1;
    dout_ready = rand_rdy ? ($urandom_range(0, 99) < 30) : force_rdy;
  end

  // Scoreboard and protocol monitor, sampled on the falling edge.
  logic [41:0] q [$];
  logic [41:0] e;
  logic [41:0] prev_beat = '0;
  logic        prev_stall = 1'b0;
  int          issued = 0;
  int          accepted = 0;
  int          beats = 0;
  int          last_hs_edge = 0;
  logic [9:0]  first_idx = '1;

  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      issued     = 0;
      accepted   = 0;
      beats      = 0;
      prev_stall = 1'b0;
    end else begin
      if (busy) check("occupancy_le2", 64'((issued - accepted) <= 2), 64'd1);
      if (prev_stall) check("stall_hold", 64'({dout_valid, dout_index, dout_data}), 64'({1'b1, prev_beat}));
      if (ram_rd_en) begin
        q.push_back({1'b0, ram_addr, mem[ram_addr]});
        issued++;
`ifdef RAM_DUMP_CHECKSUM_EN
        if (ram_addr == 9'(DEPTH - 1)) q.push_back({10'(DEPTH), exp_sum});
`endif
      end
      if (dout_valid && dout_ready) begin
        check("sb_has_entry", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("beat", 64'({dout_index, dout_data}), 64'(e));
        end
`ifdef RAM_DUMP_CHECKSUM_EN
        if (dout_index == 10'(DEPTH)) check("trailer_sum", 64'(dout_data), 64'h0001_FF00);
`endif
        if (beats == 0) first_idx = dout_index;
        beats++;
        if (dout_index < 10'(DEPTH)) accepted++;
        last_hs_edge = cyc + 1;
      end
      prev_stall = dout_valid && !dout_ready;
      prev_beat  = {dout_index, dout_data};
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic run_dump(input bit rnd);
    int t_trig;
    @(negedge clk);
    stop_i = 1'b1;
    t_trig = cyc + 1;
    @(negedge clk);
    check("busy_after_trigger", 64'({busy, done}), 64'b10);
    while (!dout_valid && (cyc - t_trig) < 20) @(negedge clk);
    check("first_valid_latency", 64'(cyc - t_trig), 64'd2);
    while (!done && (cyc - t_trig) < 20000) begin
      if (rnd && beats > 50) stop_i = 1'b0;
      @(negedge clk);
    end
    check("done_seen", 64'(done), 64'd1);
    if (!rnd) check("done_latency", 64'(cyc - t_trig), 64'(DEPTH + 2 + TRL));
    check("done_on_last_beat", 64'(cyc), 64'(last_hs_edge));
    check("beat_count", 64'(beats), 64'(DEPTH + TRL));
    check("sb_drained", 64'(q.size()), 64'd0);
    check("busy_cleared", 64'(busy), 64'd0);
  endtask

  int n0;

  initial begin
    rst = 1'b0;
    stop_i = 1'b0;
    dout_ready = 1'b0;
    ram_rdata = '0;
    exp_sum = '0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef RAM_DUMP_CHECKSUM_EN
      mem[i] = 32'(i);
`else
      mem[i] = 32'(i * 3);
`endif
      exp_sum = exp_sum + mem[i];
    end

    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 64'd0);
    #1 rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outputs", outs(), 64'd0);
    end

    force_rdy = 1'b1;
    run_dump(1'b0);

    n0 = issued;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      stop_i = ~stop_i;
    end
    repeat (4) @(negedge clk);
    check("no_reissue_after_done", 64'(issued), 64'(n0));
    check("done_sticky", 64'({busy, done}), 64'b01);

    stop_i = 1'b0;
    apply_reset();
    rand_rdy = 1'b1;
    run_dump(1'b1);
    rand_rdy = 1'b0;

    stop_i = 1'b0;
    apply_reset();
    @(negedge clk);
    stop_i = 1'b1;
    for (int i = 0; i < 1000 && beats < 100; i++) @(negedge clk);
    check("reached_beat_100", 64'(beats >= 100), 64'd1);
    #2 rst = 1'b0;
    #1 check("abort_outputs", outs(), 64'd0);
    stop_i = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    run_dump(1'b0);
    check("restart_first_index", 64'(first_idx), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
